alu_pipe: RTL and testbench

- Parametrised, registered successor to the 64-bit combinational ALU used in the execute stage.
- Accepts one operation per cycle through a valid/ready handshake and returns the result one cycle later through a single output register with backpressure.
- Keeps a Y86-style condition-code register (ZF, SF, OF) that the execute stage reads for cmov/jXX decisions.

---
 rtl/alu_pipe_if.sv | 37 +++
 rtl/alu_pipe.sv | 92 +++++++++
 tb/tb_alu_pipe.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Operation/result bundle for alu_pipe.
// Handshake: an operation transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A producer
// holding valid high keeps its payload stable until the transfer, and ready may
// depend combinationally on the opposite side's ready but never on valid.
interface alu_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             set_cc;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic [TAG_W-1:0] tag_out;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;

  // Producer/consumer side (execute stage or bench).
  modport master (
    output in_valid, op, a, b, set_cc, tag_in, out_ready,
    input  in_ready, out_valid, result, ovf, tag_out, cc_zf, cc_sf, cc_of
  );

  // ALU side.
  modport slave (
    input  in_valid, op, a, b, set_cc, tag_in, out_ready,
    output in_ready, out_valid, result, ovf, tag_out, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU: add/sub/and/xor with one result register, a valid/ready
// handshake on both sides and a Y86-style condition-code register (ZF/SF/OF).
module alu_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic [TAG_W-1:0] tag_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;

  logic             accept;
  logic [WIDTH-1:0] r_next;
  logic             ovf_next;

  // The result register may take a new op when empty or being drained this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.tag_out   = tag_q;
  assign bus.cc_zf     = zf_q;
  assign bus.cc_sf     = sf_q;
  assign bus.cc_of     = of_q;

  // Combinational ALU result and signed overflow for the presented operation.
  always_comb begin
    r_next   = '0;
    ovf_next = 1'b0;
    case (bus.op)
      OP_ADD: begin
        r_next   = bus.a + bus.b;
        ovf_next = (bus.a[MSB] == bus.b[MSB]) && (r_next[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        r_next   = bus.a - bus.b;
        ovf_next = (bus.a[MSB] != bus.b[MSB]) && (r_next[MSB] != bus.a[MSB]);
      end
      OP_AND: begin
        r_next = bus.a & bus.b;
      end
      default: begin
        r_next = bus.a ^ bus.b;
      end
    endcase
  end

  // Result register: load on accept, drop valid on a retire with no new op.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      tag_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= r_next;
      ovf_q       <= ovf_next;
      tag_q       <= bus.tag_in;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Condition codes change only when an accepted op asks for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (accept && bus.set_cc) begin
      zf_q <= (r_next == '0);
      sf_q <= r_next[MSB];
      of_q <= ovf_next;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 64-bit and 8-bit instances on a shared clock.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_pipe_if #(.WIDTH(64), .TAG_W(4)) b64 ();
  alu_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();

  alu_pipe #(.WIDTH(64), .TAG_W(4)) u64 (.clk(clk), .rst(rst), .bus(b64));
  alu_pipe #(.WIDTH(8),  .TAG_W(4)) u8  (.clk(clk), .rst(rst), .bus(b8));

  // Clock
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive64(input logic v, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic scc, input logic [3:0] tag);
    b64.in_valid = v;
    b64.op       = op;
    b64.a        = a;
    b64.b        = b;
    b64.set_cc   = scc;
    b64.tag_in   = tag;
  endtask

  task automatic drive8(input logic v, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic scc, input logic [3:0] tag);
    b8.in_valid = v;
    b8.op       = op;
    b8.a        = a;
    b8.b        = b;
    b8.set_cc   = scc;
    b8.tag_in   = tag;
  endtask

  task automatic chk_cc64(input string tag, input logic zf, input logic sf, input logic of);
    chk({tag, "_zf"}, {63'd0, b64.cc_zf}, {63'd0, zf});
    chk({tag, "_sf"}, {63'd0, b64.cc_sf}, {63'd0, sf});
    chk({tag, "_of"}, {63'd0, b64.cc_of}, {63'd0, of});
  endtask

  // Golden 64-bit model: {ovf, result}.
  function automatic logic [64:0] gold(input logic [1:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
    logic [63:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      2'd0: begin r = a + b; v = (a[63] == b[63]) && (r[63] != a[63]); end
      2'd1: begin r = a - b; v = (a[63] != b[63]) && (r[63] != a[63]); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {v, r};
  endfunction

  initial begin
    logic [64:0] g;
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    drive8(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'd0);
    b64.out_ready = 1'b1;
    b8.out_ready  = 1'b1;

    // Reset, push CC away from reset values, then reset again.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    drive64(1'b1, 2'd1, 64'd0, 64'd1, 1'b1, 4'd1);
    tick();
    chk_cc64("pre_rst_cc", 1'b0, 1'b1, 1'b0);
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
    chk("rst_result", b64.result, 64'd0);
    chk("rst_tag", {60'd0, b64.tag_out}, 64'd0);
    chk_cc64("rst_cc", 1'b1, 1'b0, 1'b0);
    chk("rst_in_ready", {63'd0, b64.in_ready}, 64'd1);

    // Back-to-back add overflow then sub underflow.
    drive64(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd2);
    tick();
    chk("add_ovf_valid", {63'd0, b64.out_valid}, 64'd1);
    chk("add_ovf_result", b64.result, 64'h8000_0000_0000_0000);
    chk("add_ovf_ovf", {63'd0, b64.ovf}, 64'd1);
    chk("add_ovf_tag", {60'd0, b64.tag_out}, 64'd2);
    chk_cc64("add_ovf_cc", 1'b0, 1'b1, 1'b1);
    drive64(1'b1, 2'd1, 64'd0, 64'd1, 1'b1, 4'd3);
    tick();
    chk("sub_valid", {63'd0, b64.out_valid}, 64'd1);
    chk("sub_result", b64.result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_ovf", {63'd0, b64.ovf}, 64'd0);
    chk("sub_tag", {60'd0, b64.tag_out}, 64'd3);
    chk_cc64("sub_cc", 1'b0, 1'b1, 1'b0);
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    tick();
    chk("drain_valid", {63'd0, b64.out_valid}, 64'd0);
    chk("drain_hold", b64.result, 64'hFFFF_FFFF_FFFF_FFFF);

    // Legacy sweep with CC untouched.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 8; i++) begin
        drive64(1'b1, 2'(op), 64'(62 - i), 64'(63 - i), 1'b0, 4'(i));
        g = gold(2'(op), 64'(62 - i), 64'(63 - i));
        tick();
        chk("sweep_result", b64.result, g[63:0]);
        chk("sweep_ovf", {63'd0, b64.ovf}, {63'd0, g[64]});
      end
    end
    chk_cc64("sweep_cc", 1'b1, 1'b0, 1'b0);

    // Backpressure: hold the AND result while an XOR waits.
    drive64(1'b1, 2'd2, 64'hF0, 64'h3C, 1'b0, 4'd5);
    tick();
    chk("bp_and_result", b64.result, 64'h30);
    chk("bp_and_tag", {60'd0, b64.tag_out}, 64'd5);
    b64.out_ready = 1'b0;
    drive64(1'b1, 2'd3, 64'hFF, 64'hFF, 1'b0, 4'd9);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", {63'd0, b64.in_ready}, 64'd0);
      tick();
      chk("bp_hold_result", b64.result, 64'h30);
      chk("bp_hold_tag", {60'd0, b64.tag_out}, 64'd5);
      chk("bp_hold_valid", {63'd0, b64.out_valid}, 64'd1);
    end
    b64.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, b64.in_ready}, 64'd1);
    tick();
    chk("bp_xor_result", b64.result, 64'd0);
    chk("bp_xor_tag", {60'd0, b64.tag_out}, 64'd9);
    chk("bp_xor_valid", {63'd0, b64.out_valid}, 64'd1);
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    tick();
    chk("bp_drain_valid", {63'd0, b64.out_valid}, 64'd0);
    chk("bp_drain_tag", {60'd0, b64.tag_out}, 64'd9);

    // set_cc gating.
    drive64(1'b1, 2'd0, 64'd1, 64'd1, 1'b1, 4'd4);
    tick();
    chk("cc_add_result", b64.result, 64'd2);
    chk_cc64("cc_add", 1'b0, 1'b0, 1'b0);
    drive64(1'b1, 2'd3, 64'd5, 64'd5, 1'b0, 4'd6);
    tick();
    chk("cc_xor0_result", b64.result, 64'd0);
    chk_cc64("cc_xor0", 1'b0, 1'b0, 1'b0);
    drive64(1'b1, 2'd3, 64'd5, 64'd5, 1'b1, 4'd7);
    tick();
    chk("cc_xor1_result", b64.result, 64'd0);
    chk_cc64("cc_xor1", 1'b1, 1'b0, 1'b0);
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);

    // 8-bit instance: overflow both ways, then reset while valid.
    drive8(1'b1, 2'd0, 8'h7F, 8'h01, 1'b1, 4'd1);
    tick();
    chk("w8_add_result", {56'd0, b8.result}, 64'h80);
    chk("w8_add_ovf", {63'd0, b8.ovf}, 64'd1);
    drive8(1'b1, 2'd1, 8'h80, 8'h01, 1'b1, 4'd2);
    tick();
    chk("w8_sub_result", {56'd0, b8.result}, 64'h7F);
    chk("w8_sub_ovf", {63'd0, b8.ovf}, 64'd1);
    chk("w8_sub_of", {63'd0, b8.cc_of}, 64'd1);
    chk("w8_sub_valid", {63'd0, b8.out_valid}, 64'd1);
    drive8(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("w8_rst_valid", {63'd0, b8.out_valid}, 64'd0);
    chk("w8_rst_result", {56'd0, b8.result}, 64'd0);
    chk("w8_rst_zf", {63'd0, b8.cc_zf}, 64'd1);
    chk("w8_rst_sf", {63'd0, b8.cc_sf}, 64'd0);
    chk("w8_rst_of", {63'd0, b8.cc_of}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
